// File: rtl/proc_core_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_core_if
// Brief    : Run/DIN command inputs and Done/p_Q/BusWires status outputs
//            of the multicycle register-datapath processor.
// Revision : 1.0 - initial release
// ============================================================================
interface proc_core_if #(
  parameter int DW = 16
);
  logic          Run;
  logic [DW-1:0] DIN;
  logic          Done;
  logic [1:0]    p_Q;
  logic [DW-1:0] BusWires;

  // Host side: supplies instructions, observes status
  modport master (
    output Run, DIN,
    input  Done, p_Q, BusWires
  );

  // Processor side
  modport slave (
    input  Run, DIN,
    output Done, p_Q, BusWires
  );
endinterface
`default_nettype wire

// File: rtl/proc_core.sv
`default_nettype none
// ============================================================================
// Module   : proc_core
// Brief    : Multicycle 8-register processor. One instruction is fetched
//            from DIN per Run-qualified T0 and executed over 2-4 steps
//            (mv/mvi/nop in T1, add/sub in T3) over a single shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module proc_core #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  proc_core_if.slave   bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] c_op_mv  = 3'b000;
  localparam logic [2:0] c_op_mvi = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;

  step_t         r_step;
  step_t         w_step_nxt;
  logic [8:0]    r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_g;
  logic [DW-1:0] r_regs [NREG];

  logic [2:0]    w_op;
  logic [2:0]    w_rx;
  logic [2:0]    w_ry;
  logic          w_gout;
  logic          w_dinout;
  logic [2:0]    w_rsel;
  logic          w_rin;
  logic          w_ain;
  logic          w_gin;
  logic          w_irin;
  logic          w_done;
  logic [DW-1:0] w_bus;
  logic [DW-1:0] w_alu;

  assign w_op = r_ir[8:6];
  assign w_rx = r_ir[5:3];
  assign w_ry = r_ir[2:0];

  // Step sequencing and per-step control: exactly one bus source is chosen
  // each step; DIN is the default source (T0 fetch, mvi immediate, nop).
  always_comb begin
    w_step_nxt = r_step;
    w_gout     = 1'b0;
    w_dinout   = 1'b1;
    w_rsel     = w_ry;
    w_rin      = 1'b0;
    w_ain      = 1'b0;
    w_gin      = 1'b0;
    w_irin     = 1'b0;
    w_done     = 1'b0;
    case (r_step)
      T0: begin
        if (bus.Run) begin
          w_irin     = 1'b1;
          w_step_nxt = T1;
        end
      end
      T1: begin
        case (w_op)
          c_op_mv: begin
            w_dinout = 1'b0;
            w_rin    = 1'b1;
            w_done   = 1'b1;
          end
          c_op_mvi: begin
            w_rin  = 1'b1;
            w_done = 1'b1;
          end
          c_op_add, c_op_sub: begin
            w_dinout = 1'b0;
            w_rsel   = w_rx;
            w_ain    = 1'b1;
          end
          default: begin
            // Opcodes 1xx retire here without touching any register
            w_done = 1'b1;
          end
        endcase
        w_step_nxt = w_done ? T0 : T2;
      end
      T2: begin
        w_dinout   = 1'b0;
        w_gin      = 1'b1;
        w_step_nxt = T3;
      end
      default: begin
        w_gout     = 1'b1;
        w_dinout   = 1'b0;
        w_rin      = 1'b1;
        w_done     = 1'b1;
        w_step_nxt = T0;
      end
    endcase
  end

  // Shared bus: G has priority over DIN, which has priority over Rout
  always_comb begin
    if (w_gout)
      w_bus = r_g;
    else if (w_dinout)
      w_bus = bus.DIN;
    else
      w_bus = r_regs[w_rsel];
  end

  // Adder/subtractor; only bit 0 of the opcode distinguishes add from sub
  always_comb begin
    w_alu = w_op[0] ? (r_a - w_bus) : (r_a + w_bus);
  end

  assign bus.BusWires = reset_n ? w_bus : '0;
  assign bus.Done     = w_done;
  assign bus.p_Q      = r_step;

  // Step counter and instruction register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step <= T0;
      r_ir   <= '0;
    end else begin
      r_step <= w_step_nxt;
      if (w_irin)
        r_ir <= bus.DIN[8:0];
    end
  end

  // Datapath registers: A, G and the general register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a <= '0;
      r_g <= '0;
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else begin
      if (w_ain)
        r_a <= w_bus;
      if (w_gin)
        r_g <= w_alu;
      if (w_rin)
        r_regs[w_rx] <= w_bus;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_core
// Brief    : Scoreboard bench for proc_core. Stimulus tasks queue the expected
//            step and bus value of every Done pulse; a monitor pops and
//            compares whenever Done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_core;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [1:0]  pq;
    logic [15:0] bus;
    bit          chk_bus;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  proc_core_if #(.DW(16)) ifc ();

  proc_core #(.DW(16), .NREG(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {7'd0, op, x, y};
  endfunction

  function automatic void expect_done(input logic [1:0] pq, input logic [15:0] b, input bit c);
    sb.push_back('{pq, b, c});
  endfunction

  // One clock: drive inputs, check step and Done mid-cycle, advance
  task automatic cyc(input logic run, input logic [15:0] din, input logic [1:0] pq,
                     input logic done, input string tag);
    ifc.Run = run;
    ifc.DIN = din;
    #2;
    chk({tag, " p_Q"}, 16'(ifc.p_Q), 16'(pq));
    chk({tag, " Done"}, 16'(ifc.Done), 16'(done));
    @(posedge clk);
    #1;
  endtask

  task automatic mvi(input logic [15:0] word, input logic [15:0] imm);
    cyc(1'b1, word, 2'd0, 1'b0, "mvi T0");
    expect_done(2'd1, imm, 1'b1);
    cyc(1'b1, imm, 2'd1, 1'b1, "mvi T1");
  endtask

  task automatic mv(input logic [2:0] x, input logic [2:0] y, input logic [15:0] exp);
    cyc(1'b1, ins(3'b000, x, y), 2'd0, 1'b0, "mv T0");
    expect_done(2'd1, exp, 1'b1);
    cyc(1'b1, 16'hDEAD, 2'd1, 1'b1, "mv T1");
  endtask

  task automatic alu(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                     input logic [15:0] exp);
    cyc(1'b1, ins(op, x, y), 2'd0, 1'b0, "alu T0");
    cyc(1'b1, 16'hBEEF, 2'd1, 1'b0, "alu T1");
    cyc(1'b1, 16'hBEEF, 2'd2, 1'b0, "alu T2");
    expect_done(2'd3, exp, 1'b1);
    cyc(1'b1, 16'hBEEF, 2'd3, 1'b1, "alu T3");
  endtask

  task automatic nop(input logic [15:0] word);
    cyc(1'b1, word, 2'd0, 1'b0, "nop T0");
    expect_done(2'd1, 16'h0000, 1'b0);
    cyc(1'b1, 16'h5555, 2'd1, 1'b1, "nop T1");
  endtask

  // Monitor: every Done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ifc.Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected Done: p_Q=%0d BusWires=%h, expected no Done (t=%0t)",
                 ifc.p_Q, ifc.BusWires, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("done p_Q", 16'(ifc.p_Q), 16'(mon_e.pq));
        if (mon_e.chk_bus)
          chk("done BusWires", ifc.BusWires, mon_e.bus);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    ifc.Run = 1'b0;
    ifc.DIN = 16'hA5A5;
    @(posedge clk);
    #1;
    chk("reset p_Q", 16'(ifc.p_Q), 16'd0);
    chk("reset Done", 16'(ifc.Done), 16'd0);
    chk("reset BusWires", ifc.BusWires, 16'h0000);
    reset_n = 1'b1;

    // Idle with Run low: counter holds T0, bus mirrors DIN
    for (int i = 0; i < 5; i++) begin
      ifc.DIN = 16'h1230 + 16'(i);
      #2;
      chk("idle BusWires", ifc.BusWires, 16'h1230 + 16'(i));
      cyc(1'b0, 16'h1230 + 16'(i), 2'd0, 1'b0, "idle");
    end

    // Basic program; upper DIN bits of the first word must be ignored
    mvi(16'hFE40, 16'h0005);          // mvi R0,#5
    mvi(16'h0048, 16'h0003);          // mvi R1,#3
    alu(3'b010, 3'd0, 3'd1, 16'h0008); // add R0,R1 -> 8
    alu(3'b011, 3'd1, 3'd0, 16'hFFFB); // sub R1,R0 -> 3-8 wraps
    mv(3'd2, 3'd1, 16'hFFFB);          // mv R2,R1
    mv(3'd2, 3'd2, 16'hFFFB);          // mv R2,R2 unchanged
    mv(3'd7, 3'd2, 16'hFFFB);          // mv R7,R2

    // Reset asserted during T2 of add R3,R3
    mvi(16'h0058, 16'h0007);          // mvi R3,#7
    cyc(1'b1, ins(3'b010, 3'd3, 3'd3), 2'd0, 1'b0, "rst T0");
    cyc(1'b1, 16'hBEEF, 2'd1, 1'b0, "rst T1");
    #2;
    chk("rst pre p_Q", 16'(ifc.p_Q), 16'd2);
    reset_n = 1'b0;
    #1;
    chk("rst async p_Q", 16'(ifc.p_Q), 16'd0);
    chk("rst async Done", 16'(ifc.Done), 16'd0);
    chk("rst async BusWires", ifc.BusWires, 16'h0000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mv(3'd4, 3'd3, 16'h0000);          // R3 cleared, no write-back
    mv(3'd5, 3'd0, 16'h0000);          // R0 cleared
    mv(3'd6, 3'd7, 16'h0000);          // R7 cleared

    // Rx == Ry arithmetic
    mvi(16'h0050, 16'h1234);          // mvi R2,#0x1234
    alu(3'b010, 3'd2, 3'd2, 16'h2468); // add R2,R2 doubles
    alu(3'b011, 3'd2, 3'd2, 16'h0000); // sub R2,R2 -> 0
    mv(3'd3, 3'd2, 16'h0000);

    // Back-to-back run: mvi, add, mv, nop(111), then confirm no write
    mvi(16'h0070, 16'h00AA);          // mvi R6,#0xAA
    alu(3'b010, 3'd6, 3'd6, 16'h0154); // add R6,R6
    mv(3'd5, 3'd6, 16'h0154);          // mv R5,R6
    nop(16'h01EE);                    // 111 with Rx=R5
    nop(16'h012D);                    // 100 with Rx=R5
    mv(3'd4, 3'd5, 16'h0154);          // R5 untouched

    cyc(1'b0, 16'h0000, 2'd0, 1'b0, "final idle");
    chk("scoreboard drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_core.md
Name: proc_core

Overview:
- Multicycle 8-register datapath processor, instantiated inside nios_system as processor_0.
- Fetches one instruction per Run-qualified cycle from DIN and executes it over 2–4 time-steps.
- Reports completion on Done and its current time-step on p_Q; these drive LEDR[17] and the p_Q status net.
- Run is driven from SW[17]. Instruction and immediate words arrive on DIN from the Nios-side peripheral logic.

Parameters:
- DW, 16, data/bus width of DIN, registers, A, G, BusWires
- NREG, 8, number of general registers R0..R7 (fixed by the 3-bit register fields)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- Run  in  1  start: sampled in step T0 to fetch an instruction
- DIN  in  DW  instruction word in T0; immediate data in T1 of mvi
- Done  out  1  high during the final step of an instruction
- p_Q  out  2  current time-step: 0=T0 .. 3=T3
- BusWires  out  DW  internal bus value (debug/LED mirror)

Behaviour:
- Reset (reset_n=0, asynchronous, effective any cycle including mid-instruction):
  - Step counter=T0; IR, A, G, R0..R7 all = 0.
  - Done=0, p_Q=0, BusWires=0.
  - An instruction in progress is abandoned with no register write.
- Instruction format, DIN[8:0] = III XXX YYY:
  - III: 000 mv Rx,Ry; 001 mvi Rx,#imm; 010 add Rx,Ry; 011 sub Rx,Ry.
  - III=1xx is a NOP: completes in T1 with Done=1 and no write.
  - DIN[DW-1:9] is ignored.
- Step counter: 2-bit register T0→T1→T2→T3.
  - Returns to T0 in the cycle after Done=1.
  - In T0 it advances only if Run=1; otherwise it holds T0.
  - p_Q mirrors the counter directly.
- T0:
  - If Run=1, IR<=DIN[8:0] at the clock edge.
  - BusWires=DIN; Done=0.
- T1:
  - mv: BusWires=Ry; Rx<=BusWires; Done=1.
  - mvi: BusWires=DIN (immediate presented this cycle); Rx<=DIN; Done=1.
  - add/sub: BusWires=Rx; A<=Rx; Done=0.
- T2 (add/sub only):
  - BusWires=Ry.
  - G<=A+Ry for add, A−Ry for sub; modulo 2^DW, no carry/borrow flag.
  - Done=0.
- T3 (add/sub only): BusWires=G; Rx<=G; Done=1.
- Done is combinational from step and IR, so it is high for exactly one clock per instruction.
- Run is ignored outside T0. Dropping Run mid-instruction does not stop execution.
- Rx==Ry is legal:
  - add R2,R2 doubles R2.
  - sub R2,R2 yields 0.
  - mv R2,R2 leaves R2 unchanged.
- Bus source priority, exactly one source per step: Gout > DINout > Rout. Any other combination is a design error and must never occur.
- Back-to-back: with Run held at 1, a new fetch occurs in the T0 immediately after each Done. Throughput is 1 instruction per 2 clocks (mv/mvi) or per 4 clocks (add/sub).

Test Plan:
- Reset release, Run=0 for 5 clocks → p_Q=0, Done=0, BusWires equals DIN (all registers 0).
- mvi R0,#5 (DIN=0x040, then 0x0005), then mvi R1,#3 → Done high in each T1; R0=5, R1=3 after 4 clocks.
- add R0,R1 (DIN=0x081) after the above → p_Q 0,1,2,3; Done only at T3; BusWires=0x0008 at T3; R0=8.
- sub R1,R0 with R1=3, R0=8 (DIN=0x0C8) → R1=0xFFFB (wrap-around); mv R2,R1 (0x011) → R2=0xFFFB, Done at T1.
- Assert reset_n=0 during T2 of add R3,R3 with R3=7 → p_Q=0 immediately; R3=0; no Done pulse.
- Hold Run=1 with sequence mvi, add, mv, opcode 111 → Done pulses at clocks 2, 6, 8, 10 after start; the 111 word causes no register change.
